// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM encoding and the legality/alignment helper functions.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } state_e;

    // Stores only have signed widths; loads add the unsigned byte/half forms.
    function automatic logic legal_op(input logic store, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte accesses can never be misaligned; halves need bit 0 clear, words both bits.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_check.sv
// Combinational request decode: flags an operation that must be rejected
// without touching memory (unsupported funct3 or misaligned address).
module dmem_lsu_check (
    input  logic       store,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       err
);
    import dmem_lsu_pkg::*;

    // An op is rejected if its width code is illegal or its address is misaligned.
    always_comb begin
        err = !legal_op(store, funct3) || misaligned(funct3, addr_lo);
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving the data-memory port: accepts one op per handshake,
// runs a single-cycle memory access and returns a tagged response.
module dmem_lsu #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    input  logic [4:0]         req_rd,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [D_WIDTH-1:0] resp_rdata,
    output logic [4:0]         resp_rd,
    output logic               resp_err,
    output logic               mem_cs,
    output logic               mem_load_store,
    output logic [2:0]         mem_funct3,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata
);
    import dmem_lsu_pkg::*;

    state_e             state_q, state_d;
    logic [D_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]         resp_rd_q, resp_rd_d;
    logic               resp_err_q, resp_err_d;
    logic               mem_cs_q, mem_cs_d;
    logic               mem_load_store_q, mem_load_store_d;
    logic [2:0]         mem_funct3_q, mem_funct3_d;
    logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic               req_err;
    logic               unused_addr_hi;

    // Address bits above the word index are intentionally ignored.
    assign unused_addr_hi = ^req_addr[31:A_WIDTH+2];

    dmem_lsu_check u_check (
        .store   (req_store),
        .funct3  (req_funct3),
        .addr_lo (req_addr[1:0]),
        .err     (req_err)
    );

    // Next-state and datapath: errors skip ACCESS, loads capture raw memory data.
    always_comb begin
        state_d          = state_q;
        resp_rdata_d     = resp_rdata_q;
        resp_rd_d        = resp_rd_q;
        resp_err_d       = resp_err_q;
        mem_cs_d         = mem_cs_q;
        mem_load_store_d = mem_load_store_q;
        mem_funct3_d     = mem_funct3_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    resp_rd_d = req_rd;
                    if (req_err) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else begin
                        resp_err_d       = 1'b0;
                        mem_cs_d         = 1'b1;
                        mem_load_store_d = req_store;
                        mem_funct3_d     = req_funct3;
                        mem_addr_d       = req_addr[A_WIDTH+1:2];
                        mem_wdata_d      = req_wdata;
                        state_d          = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_cs_d     = 1'b0;
                resp_rdata_d = mem_load_store_q ? '0 : mem_rdata;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                mem_cs_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops mem_cs at once and discards any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            resp_rdata_q     <= '0;
            resp_rd_q        <= '0;
            resp_err_q       <= 1'b0;
            mem_cs_q         <= 1'b0;
            mem_load_store_q <= 1'b0;
            mem_funct3_q     <= '0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_rd_q        <= resp_rd_d;
            resp_err_q       <= resp_err_d;
            mem_cs_q         <= mem_cs_d;
            mem_load_store_q <= mem_load_store_d;
            mem_funct3_q     <= mem_funct3_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_rdata     = resp_rdata_q;
    assign resp_rd        = resp_rd_q;
    assign resp_err       = resp_err_q;
    assign mem_cs         = mem_cs_q;
    assign mem_load_store = mem_load_store_q;
    assign mem_funct3     = mem_funct3_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: a table of directed ops against a small negedge
// memory model, plus hand-written backpressure and mid-access reset sequences.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_cs;
    logic        mem_load_store;
    logic [2:0]  mem_funct3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [256];
    bit          preloaded = 1'b0;
    int          cs_count = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        exp_err;
        logic [7:0]  exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    dmem_lsu #(.D_WIDTH(32), .A_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_rd        (resp_rd),
        .resp_err       (resp_err),
        .mem_cs         (mem_cs),
        .mem_load_store (mem_load_store),
        .mem_funct3     (mem_funct3),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: samples on negedge, returns the raw stored word for loads.
    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            mem[12] = 32'hFFFFFF80;
            preloaded = 1'b1;
        end
        if (mem_cs) begin
            cs_count = cs_count + 1;
            if (mem_load_store) mem[mem_addr] = mem_wdata;
            else                mem_rdata = mem[mem_addr];
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic completeHandshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("resp_valid_after_handshake", resp_valid, 0);
        checkOutput("req_ready_after_handshake", req_ready, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int cs_before;
        cs_before  = cs_count;
        req_store  = v.store;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        req_valid  = 1'b1;
        checkOutput("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("req_ready_busy", req_ready, 0);
        if (v.exp_err) begin
            checkOutput("err_mem_cs", mem_cs, 0);
            checkOutput("err_resp_valid_early", resp_valid, 1);
        end else begin
            checkOutput("access_mem_cs", mem_cs, 1);
            checkOutput("access_resp_valid", resp_valid, 0);
            checkOutput("access_mem_addr", mem_addr, v.exp_addr);
            checkOutput("access_load_store", mem_load_store, v.store);
            checkOutput("access_funct3", mem_funct3, v.f3);
            if (v.store) checkOutput("access_wdata", mem_wdata, v.wdata);
            @(posedge clk); #1;
            checkOutput("after_access_mem_cs", mem_cs, 0);
            checkOutput("after_access_resp_valid", resp_valid, 1);
        end
        checkOutput("cs_pulses", cs_count - cs_before, v.exp_err ? 1 - 1 : 1);
        checkOutput("resp_rdata", resp_rdata, v.exp_rdata);
        checkOutput("resp_rd", resp_rd, v.rd);
        checkOutput("resp_err", resp_err, v.exp_err);
        completeHandshake();
    endtask

    initial begin
        //            store  f3      addr          wdata         rd    err   addr   rdata
        vecs[0]  = '{1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 5'd1, 1'b0, 8'h04, 32'h00000000};
        vecs[1]  = '{1'b0, 3'b010, 32'h00000010, 32'h0,        5'd2, 1'b0, 8'h04, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 3'b010, 32'h00000012, 32'h0,        5'd3, 1'b1, 8'h00, 32'h00000000};
        vecs[3]  = '{1'b0, 3'b011, 32'h00000000, 32'h0,        5'd4, 1'b1, 8'h00, 32'h00000000};
        vecs[4]  = '{1'b1, 3'b100, 32'h00000000, 32'h11111111, 5'd5, 1'b1, 8'h00, 32'h00000000};
        vecs[5]  = '{1'b1, 3'b001, 32'h00000021, 32'h22222222, 5'd6, 1'b1, 8'h00, 32'h00000000};
        vecs[6]  = '{1'b1, 3'b001, 32'h00000022, 32'h1234ABCD, 5'd7, 1'b0, 8'h08, 32'h00000000};
        vecs[7]  = '{1'b0, 3'b000, 32'h00000033, 32'h0,        5'd8, 1'b0, 8'h0C, 32'hFFFFFF80};
        vecs[8]  = '{1'b0, 3'b010, 32'hFFFFFC10, 32'h0,        5'd9, 1'b0, 8'h04, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 3'b101, 32'h00000022, 32'h0,        5'd10, 1'b0, 8'h08, 32'h1234ABCD};
        vecs[10] = '{1'b1, 3'b101, 32'h00000000, 32'h33333333, 5'd11, 1'b1, 8'h00, 32'h00000000};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        resp_ready = 1'b0;

        #12;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        checkOutput("rst_resp_rdata", resp_rdata, 0);
        checkOutput("rst_resp_rd", resp_rd, 0);
        checkOutput("rst_mem_cs", mem_cs, 0);
        checkOutput("rst_mem_load_store", mem_load_store, 0);
        checkOutput("rst_mem_funct3", mem_funct3, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Backpressure: response held 5 cycles while a second request waits.
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h00000010;
        req_rd     = 5'd12;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_store  = 1'b1;
        req_addr   = 32'h00000040;
        req_wdata  = 32'h00000055;
        req_rd     = 5'd13;
        @(posedge clk); #1;
        checkOutput("bp_resp_valid", resp_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_req_ready", req_ready, 0);
            checkOutput("bp_resp_valid_held", resp_valid, 1);
            checkOutput("bp_resp_rdata_held", resp_rdata, 32'hDEADBEEF);
            checkOutput("bp_resp_rd_held", resp_rd, 12);
            checkOutput("bp_mem_cs", mem_cs, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("bp_idle_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("bp_next_mem_cs", mem_cs, 1);
        checkOutput("bp_next_mem_addr", mem_addr, 8'h10);
        checkOutput("bp_next_load_store", mem_load_store, 1);
        checkOutput("bp_next_wdata", mem_wdata, 32'h55);
        @(posedge clk); #1;
        checkOutput("bp_next_resp_valid", resp_valid, 1);
        checkOutput("bp_next_resp_rd", resp_rd, 13);
        checkOutput("bp_next_resp_rdata", resp_rdata, 0);
        completeHandshake();
        checkOutput("bp_mem_written", mem[16], 32'h55);

        // Reset asserted during ACCESS: op and response are discarded.
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h00000080;
        req_wdata  = 32'hCAFEF00D;
        req_rd     = 5'd14;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rstmid_mem_cs_before", mem_cs, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_mem_cs", mem_cs, 0);
        checkOutput("rstmid_resp_valid", resp_valid, 0);
        checkOutput("rstmid_req_ready", req_ready, 1);
        checkOutput("rstmid_mem_addr", mem_addr, 0);
        checkOutput("rstmid_mem_wdata", mem_wdata, 0);
        checkOutput("rstmid_mem_load_store", mem_load_store, 0);
        checkOutput("rstmid_resp_rd", resp_rd, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("rstmid_no_resp", resp_valid, 0);
            checkOutput("rstmid_idle", req_ready, 1);
        end
        checkOutput("rstmid_store_dropped", mem[32], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit on the initiator side of the data-memory port. Accepts one load or store per handshake from the execute stage and checks alignment and funct3. Drives the memory port (cs, load_store, funct3, addr, wdata) for exactly one cycle, then captures load data. Returns a tagged response to writeback.

## Interface
Parameters:
- D_WIDTH, 32, data width of the request and memory port
- A_WIDTH, 8, memory word-index width (memory depth 2^A_WIDTH words)

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  LSU can accept (IDLE only)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code
- req_addr  in  32  byte address
- req_wdata  in  D_WIDTH  store data
- req_rd  in  5  destination register tag
- resp_valid  out  1  response available
- resp_ready  in  1  writeback accepts response
- resp_rdata  out  D_WIDTH  load result (0 for stores and errors)
- resp_rd  out  5  echoed tag
- resp_err  out  1  misaligned or illegal funct3; no memory access made
- mem_cs  out  1  memory chip select
- mem_load_store  out  1  1 = store, 0 = load
- mem_funct3  out  3  forwarded funct3
- mem_addr  out  A_WIDTH  word index = req_addr[A_WIDTH+1:2]
- mem_wdata  out  D_WIDTH  store data
- mem_rdata  in  D_WIDTH  load data; valid before the posedge that ends the access cycle (memory samples on negedge)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid is high, latch all request fields and req_rd.
  - Legal ops: loads 000/001/010/100/101; stores 000/001/010.
  - Alignment: word ops need addr[1:0]=0; half ops need addr[0]=0; byte ops are always aligned.
  - Illegal or misaligned: go to RESP with resp_err=1 and resp_rdata=0. mem_cs is never asserted.
  - Legal: register mem_* outputs, assert mem_cs=1, go to ACCESS.
- ACCESS: lasts exactly one cycle.
  - Load: capture mem_rdata into resp_rdata unmodified, because the memory performs sign/zero extension.
  - Store: resp_rdata=0.
  - Always: deassert mem_cs, go to RESP.
- RESP: resp_valid=1. Outputs resp_rdata, resp_rd and resp_err stay stable until resp_ready is high at a posedge, then go to IDLE.
- mem_addr, mem_funct3, mem_load_store and mem_wdata hold their last values outside ACCESS. Only mem_cs qualifies them.
- Width rule: req_addr bits above A_WIDTH+1 are ignored; no out-of-range error.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, resp_rd=0, mem_cs=0, mem_load_store=0, mem_funct3=0, mem_addr=0, mem_wdata=0.
- Accept at edge E0. mem_cs is high from E0 to E1.
- Store is committed by memory at E1; load data is captured at E1. resp_valid rises after E1.
- Error path: resp_valid rises after E0, one cycle earlier than a legal op.
- Best-case throughput: one op per 3 cycles (accept, access, response handshake). req_ready=0 in ACCESS and RESP.
- resp_ready held low keeps the FSM in RESP indefinitely with outputs unchanged.
- Asserting rst_n low mid-ACCESS drops mem_cs immediately (async) and discards the op and response.
- A req_valid held across the RESP→IDLE transition is accepted at the first edge spent in IDLE.

## Structure
- Package dmem_lsu_pkg holds:
  - funct3 constants F3_B/H/W/BU/HU
  - state enum
  - function legal_op(store, funct3)
  - function misaligned(funct3, addr[1:0])
- Natural sub-module: dmem_lsu_check, combinational legality/alignment decode producing err. FSM and registers stay in dmem_lsu.

## Test plan
- sw addr 0x10 data 0xDEADBEEF, then lw addr 0x10. Required: mem_cs one cycle each, mem_addr=4, load resp_rdata=0xDEADBEEF, resp_rd echoed.
- lw addr 0x12. Required: resp_err=1, resp_rdata=0, mem_cs never asserted, resp_valid one cycle after accept.
- Load funct3=011. Required: resp_err=1. Store funct3=100. Required: resp_err=1.
- lb with memory returning 0xFFFFFF80. Required: resp_rdata=0xFFFFFF80 passed unmodified, one cycle after mem_cs.
- resp_ready held low 5 cycles with req_valid high. Required: req_ready=0, outputs stable, next request accepted on the first IDLE edge.
- rst_n low during ACCESS. Required: mem_cs=0 immediately, all outputs at reset values, no resp_valid after release.
